// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared pipeline types, constants and B-immediate decode for the fetch stage
package fetch_unit_pkg;
    typedef logic [1:0] bp_state_t;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        bp_state_t   bp_state;
        logic        valid;
    } if_id_t;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [6:0]  OPC_BRANCH   = 7'b1100011;
    localparam bp_state_t   BP_WEAK_NT   = 2'b01;
    localparam if_id_t      IF_ID_BUBBLE = '{pc: 32'd0, instr: NOP_INSTR, bp_state: 2'b00, valid: 1'b0};
    function automatic logic [31:0] b_imm(input logic [31:0] instr);
        return {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction
endpackage

// File: rtl/fetch_unit_bht.sv
// fetch_unit_bht: table of 2-bit saturating branch counters with one lookup and one update port
module fetch_unit_bht import fetch_unit_pkg::*; #(
    parameter int ENTRIES = 64,
    localparam int IW = $clog2(ENTRIES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] i_rd_idx,
    output bp_state_t     o_rd_state,
    input  logic          i_wr_en,
    input  logic [IW-1:0] i_wr_idx,
    input  logic          i_wr_taken
);
    bp_state_t r_tbl [ENTRIES];
    bp_state_t w_cur;
    assign w_cur = r_tbl[i_wr_idx];
    // Lookup reads the stored value, so a same-index update only becomes visible after the edge
    assign o_rd_state = r_tbl[i_rd_idx];
    // Saturating counter update; reset returns every entry to weakly not-taken
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) r_tbl[i] <= BP_WEAK_NT;
        end else if (i_wr_en) begin
            r_tbl[i_wr_idx] <= i_wr_taken ? (w_cur == 2'b11 ? 2'b11 : w_cur + 2'b01)
                                          : (w_cur == 2'b00 ? 2'b00 : w_cur - 2'b01);
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage with next-PC selection, optional 2-bit branch predictor and the IF/ID register
// Build option: define BHT_EN to add the counter table and taken prediction (otherwise always not-taken)
module fetch_unit import fetch_unit_pkg::*; #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BHT_ENTRIES = 64
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        bp_upd_valid,
    input  logic [31:0] bp_upd_pc,
    input  logic        bp_upd_taken,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic [1:0]  if_id_bp_state,
    output logic        if_id_valid
);
    logic [31:0] r_pc;
    if_id_t      r_if_id;
    bp_state_t   w_state;
    logic        w_taken;
    logic [31:0] w_next_pc;
    logic        w_unused;

    if (BHT_ENTRIES < 4 || (BHT_ENTRIES & (BHT_ENTRIES - 1)) != 0) begin : g_bad_entries
        $error("BHT_ENTRIES must be a power of two and at least 4");
    end

`ifdef BHT_EN
    localparam int IW = $clog2(BHT_ENTRIES);
    assign w_unused = ^{bp_upd_pc[31:IW+2], bp_upd_pc[1:0]};
    fetch_unit_bht #(.ENTRIES(BHT_ENTRIES)) bht (
        .clk        (clk),
        .rst        (rst),
        .i_rd_idx   (r_pc[IW+1:2]),
        .o_rd_state (w_state),
        .i_wr_en    (bp_upd_valid),
        .i_wr_idx   (bp_upd_pc[IW+1:2]),
        .i_wr_taken (bp_upd_taken)
    );
    assign w_taken = (imem_rdata[6:0] == OPC_BRANCH) && w_state[1];
`else
    assign w_unused = ^{bp_upd_valid, bp_upd_pc, bp_upd_taken};
    assign w_state  = BP_WEAK_NT;
    assign w_taken  = 1'b0;
`endif

    // Next-PC priority: redirect, then stall hold, then predicted-taken target, then sequential
    assign w_next_pc = redirect_valid ? redirect_pc :
                       stall          ? r_pc :
                       w_taken        ? r_pc + b_imm(imem_rdata) : r_pc + 32'd4;

    // PC and IF/ID: redirect inserts a bubble (beats stall), stall freezes, otherwise capture the fetch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc    <= RESET_PC;
            r_if_id <= IF_ID_BUBBLE;
        end else begin
            r_pc <= w_next_pc;
            if (redirect_valid) r_if_id <= IF_ID_BUBBLE;
            else if (!stall) r_if_id <= '{pc: r_pc, instr: imem_rdata, bp_state: w_state, valid: 1'b1};
        end
    end

    assign imem_addr      = r_pc;
    assign if_id_pc       = r_if_id.pc;
    assign if_id_instr    = r_if_id.instr;
    assign if_id_bp_state = r_if_id.bp_state;
    assign if_id_valid    = r_if_id.valid;
endmodule
